// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: turns one command into an INCR write or read burst.
// Payload is passed through combinationally; done/resp_err are registered one cycle after the final response.
//
// state | meaning
// IDLE  | waiting for a command (cmd_ready unless the done pulse is being shown)
// AW    | presenting the write address
// W     | streaming write beats from wr_* to the W channel
// B     | waiting for the write response
// AR    | presenting the read address
// R     | streaming read beats from the R channel to rd_*
module axi_burst_master #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int MASTER_ID  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic                  resp_err,
  output logic                  busy,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

  localparam logic [2:0]            AXI_SIZE  = 3'($clog2(STRB_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  resp_err_q, resp_err_d;

  // Response IDs are not checked: only one burst is ever outstanding.
  logic unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign m_axi_awid    = ID_WIDTH'(MASTER_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_arid    = ID_WIDTH'(MASTER_ID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign done          = done_q;
  assign resp_err      = resp_err_q;
  assign busy          = (state_q != S_IDLE);
  // Holding cmd_ready low during the done pulse gives the caller one cycle to see the result.
  assign cmd_ready     = (state_q == S_IDLE) && !done_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    done_d        = 1'b0;
    resp_err_d    = resp_err_q;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    rd_data       = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr & ~ADDR_MASK;
          len_d   = cmd_len;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = cmd_write ? S_AW : S_AR;
        end
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) begin
          cnt_d   = '0;
          state_d = S_W;
        end
      end
      S_W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = (cnt_q == len_q);
        if (wr_valid && m_axi_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = S_B;
        end
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          done_d     = 1'b1;
          resp_err_d = (m_axi_bresp != 2'b00);
          state_d    = S_IDLE;
        end
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          cnt_d   = '0;
          state_d = S_R;
        end
      end
      S_R: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        rd_data      = m_axi_rdata;
        rd_last      = m_axi_rlast;
        if (m_axi_rvalid && rd_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (m_axi_rlast) begin
            done_d     = 1'b1;
            resp_err_d = err_q || (m_axi_rresp != 2'b00) || (cnt_q != len_q);
            state_d    = S_IDLE;
          end else if ((m_axi_rresp != 2'b00) || (cnt_q == len_q)) begin
            // Overlong burst or bad beat: keep draining until the slave ends it.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
